// File: rtl/data_mem_responder.sv
// Data-memory responder: load/store servicing for the memory stage, RAM or IO space.
// Latency: stores commit at the request edge; load data is registered one cycle after the request.
// Backpressure: none; accepts one request per cycle, back-to-back, and never stalls.
//
// Ports:
//   MEM_CLOCK / MEM_RESET   clock, synchronous active-high reset
//   MEM_ADDR2, MEM_DIN2     request byte address and store data
//   MEM_WE2, MEM_RDEN2      store / load request strobes (both may be high together)
//   MEM_SIZE                funct3: [1:0] byte/half/word, [2] unsigned load
//   IOBUS_IN                IO read data for loads in IO space
//   MEM_DOUT2, MEM_VALID2   registered load result and its one-cycle valid pulse
//   IO_WR                   combinational IO store strobe
//   MEM_MISALIGN            sticky misaligned-access flag
//   MEM_ERR_ADDR            address of the first misaligned access since reset
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter logic [31:0] IO_BASE     = 32'h1100_0000
) (
  input  logic        MEM_CLOCK,
  input  logic        MEM_RESET,
  input  logic [31:0] MEM_ADDR2,
  input  logic [31:0] MEM_DIN2,
  input  logic        MEM_WE2,
  input  logic        MEM_RDEN2,
  input  logic [2:0]  MEM_SIZE,
  input  logic [31:0] IOBUS_IN,
  output logic [31:0] MEM_DOUT2,
  output logic        MEM_VALID2,
  output logic        IO_WR,
  output logic        MEM_MISALIGN,
  output logic [31:0] MEM_ERR_ADDR
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   ram [DEPTH_WORDS];

  logic [AW-1:0] ram_idx;
  logic [1:0]    lane;
  logic          is_io;
  logic          misalign;
  logic          store_ok;
  logic          ram_we;
  logic [3:0]    byte_en;
  logic [31:0]   wr_data;
  logic [31:0]   src_word;
  logic [31:0]   shifted;
  logic [31:0]   load_val;

  // Addresses past the RAM but below IO_BASE simply drop their upper bits and alias.
  assign ram_idx = MEM_ADDR2[AW+1:2];
  assign lane    = MEM_ADDR2[1:0];
  assign is_io   = (MEM_ADDR2 >= IO_BASE);

  always_comb begin
    misalign = 1'b0;
    case (MEM_SIZE[1:0])
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = lane[0];
      default: misalign = (lane != 2'b00);
    endcase
  end

  // A store in the reset cycle is dropped, so reset gates both the IO strobe and the RAM write.
  assign store_ok = MEM_WE2 & ~misalign & ~MEM_RESET;
  assign IO_WR    = store_ok & is_io;
  assign ram_we   = store_ok & ~is_io;

  // Store data is replicated across lanes so each enabled lane picks its bits in place.
  always_comb begin
    byte_en = 4'b0000;
    wr_data = MEM_DIN2;
    case (MEM_SIZE[1:0])
      2'b00: begin
        byte_en = 4'b0001 << lane;
        wr_data = {4{MEM_DIN2[7:0]}};
      end
      2'b01: begin
        byte_en = 4'b0011 << {lane[1], 1'b0};
        wr_data = {2{MEM_DIN2[15:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        wr_data = MEM_DIN2;
      end
    endcase
  end

  // RAM contents survive reset; only the write enable is qualified by it.
  always_ff @(posedge MEM_CLOCK) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          ram[ram_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
        end
      end
    end
  end

  // Read path samples the pre-edge word, giving read-before-write when WE2 and RDEN2 coincide.
  assign src_word = is_io ? IOBUS_IN : ram[ram_idx];
  assign shifted  = src_word >> {lane, 3'b000};

  always_comb begin
    load_val = src_word;
    case (MEM_SIZE[1:0])
      2'b00:   load_val = MEM_SIZE[2] ? {24'h000000, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = MEM_SIZE[2] ? {16'h0000, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = src_word;
    endcase
    if (misalign) begin
      load_val = 32'h0000_0000;
    end
  end

  always_ff @(posedge MEM_CLOCK) begin
    if (MEM_RESET) begin
      MEM_DOUT2    <= 32'h0000_0000;
      MEM_VALID2   <= 1'b0;
      MEM_MISALIGN <= 1'b0;
      MEM_ERR_ADDR <= 32'h0000_0000;
    end else begin
      MEM_VALID2 <= MEM_RDEN2;
      if (MEM_RDEN2) begin
        MEM_DOUT2 <= load_val;
      end
      // Only the first offending address is kept; later ones just keep the flag set.
      if ((MEM_WE2 | MEM_RDEN2) & misalign) begin
        MEM_MISALIGN <= 1'b1;
        if (!MEM_MISALIGN) begin
          MEM_ERR_ADDR <= MEM_ADDR2;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam logic [31:0] IO_BASE = 32'h1100_0000;
  localparam int unsigned DEPTH   = 16384;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, din, io_in;
  logic        we, rd;
  logic [2:0]  size;
  logic [31:0] dout, err_addr;
  logic        valid, io_wr, mis;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mdl [int];
  logic [31:0] m_dout;
  logic        m_valid, m_mis;
  logic [31:0] m_err;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .IO_BASE(IO_BASE)) dut (
    .MEM_CLOCK(clk), .MEM_RESET(rst), .MEM_ADDR2(addr), .MEM_DIN2(din),
    .MEM_WE2(we), .MEM_RDEN2(rd), .MEM_SIZE(size), .IOBUS_IN(io_in),
    .MEM_DOUT2(dout), .MEM_VALID2(valid), .IO_WR(io_wr),
    .MEM_MISALIGN(mis), .MEM_ERR_ADDR(err_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_misaligned(input logic [31:0] a, input logic [2:0] sz);
    int unsigned s = sz[1:0];
    if (s == 0) return 1'b0;
    if (s == 1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [2:0] sz);
    int unsigned off = a % 4;
    logic [31:0] v;
    int unsigned s = sz[1:0];
    if (s == 0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (!sz[2] && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (s == 1) begin
      v = (w >> (8 * off)) & 32'hFFFF;
      if (!sz[2] && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] mdl_store(input logic [31:0] w, input logic [31:0] a,
                                            input logic [31:0] d, input logic [2:0] sz);
    int unsigned off = a % 4;
    logic [31:0] mask;
    int unsigned s = sz[1:0];
    if (s == 0) begin
      mask = 32'hFF << (8 * off);
      return (w & ~mask) | ((d & 32'hFF) << (8 * off));
    end else if (s == 1) begin
      mask = 32'hFFFF << (8 * off);
      return (w & ~mask) | ((d & 32'hFFFF) << (8 * off));
    end
    return d;
  endfunction

  // One request cycle: drive, check the combinational strobe, advance, check registered outputs.
  task automatic step(input bit r, input bit w, input bit l, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] sz, input logic [31:0] io);
    bit m_io, bad, io_space;
    int idx;
    rst = r; we = w; rd = l; addr = a; din = d; size = sz; io_in = io;
    #1;
    bad      = is_misaligned(a, sz);
    io_space = (a >= IO_BASE);
    idx      = int'((a / 4) % DEPTH);
    m_io     = !r && w && io_space && !bad;
    check("io_wr", {31'b0, io_wr}, {31'b0, m_io});
    if (r) begin
      m_dout = 0; m_valid = 0; m_mis = 0; m_err = 0;
    end else begin
      m_valid = l;
      if (l) begin
        if (bad) m_dout = 0;
        else if (io_space) m_dout = mdl_load(io, a, sz);
        else m_dout = mdl_load(mdl.exists(idx) ? mdl[idx] : 32'h0, a, sz);
      end
      if ((w || l) && bad) begin
        if (!m_mis) m_err = a;
        m_mis = 1;
      end
      if (w && !bad && !io_space)
        mdl[idx] = mdl_store(mdl.exists(idx) ? mdl[idx] : 32'h0, a, d, sz);
    end
    @(posedge clk);
    #1;
    check("valid", {31'b0, valid}, {31'b0, m_valid});
    check("dout", dout, m_dout);
    check("misalign", {31'b0, mis}, {31'b0, m_mis});
    check("err_addr", err_addr, m_err);
  endtask

  task automatic idle();
    step(0, 0, 0, 32'h0, 32'h0, 3'b010, 32'h0);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [2:0]  sz;
    bit w, l;

    rst = 1; we = 0; rd = 0; addr = 0; din = 0; size = 0; io_in = 0;
    m_dout = 0; m_valid = 0; m_mis = 0; m_err = 0;

    step(1, 0, 0, 32'h0, 32'h0, 3'b010, 32'h0);
    step(1, 0, 0, 32'h0, 32'h0, 3'b010, 32'h0);
    check("reset_dout", dout, 32'h0);

    // Word store then load, valid pulse then drop
    step(0, 1, 0, 32'h100, 32'hDEADBEEF, 3'b010, 32'h0);
    step(0, 0, 1, 32'h100, 32'h0, 3'b010, 32'h0);
    check("lw_deadbeef", dout, 32'hDEADBEEF);
    idle();
    check("valid_drop", {31'b0, valid}, 32'h0);

    // Byte store, signed/unsigned byte loads
    step(0, 1, 0, 32'h103, 32'h80, 3'b000, 32'h0);
    step(0, 0, 1, 32'h103, 32'h0, 3'b000, 32'h0);
    check("lb", dout, 32'hFFFFFF80);
    step(0, 0, 1, 32'h103, 32'h0, 3'b100, 32'h0);
    check("lbu", dout, 32'h00000080);
    step(0, 0, 1, 32'h100, 32'h0, 3'b010, 32'h0);
    check("lw_after_sb", dout, 32'h80ADBEEF);

    // Half store, misaligned half load and misaligned word store
    step(0, 1, 0, 32'h102, 32'h1234, 3'b001, 32'h0);
    step(0, 0, 1, 32'h102, 32'h0, 3'b101, 32'h0);
    check("lhu", dout, 32'h00001234);
    step(0, 0, 1, 32'h101, 32'h0, 3'b001, 32'h0);
    check("mis_lh_dout", dout, 32'h0);
    check("mis_err", err_addr, 32'h101);
    step(0, 1, 0, 32'h203, 32'h12345678, 3'b010, 32'h0);
    check("mis_err_sticky", err_addr, 32'h101);

    // IO store strobe, RAM alias untouched, IO load
    step(0, 1, 0, 32'h20, 32'h77777777, 3'b010, 32'h0);
    step(0, 1, 0, 32'h1100_0020, 32'h55, 3'b010, 32'h0);
    idle();
    step(0, 0, 1, 32'h20, 32'h0, 3'b010, 32'h0);
    check("alias_kept", dout, 32'h77777777);
    step(0, 0, 1, 32'h1100_0020, 32'h0, 3'b010, 32'hCAFEF00D);
    check("io_load", dout, 32'hCAFEF00D);

    // Read-before-write
    step(0, 1, 0, 32'h40, 32'h11111111, 3'b010, 32'h0);
    step(0, 1, 1, 32'h40, 32'h22222222, 3'b010, 32'h0);
    check("rbw_old", dout, 32'h11111111);
    step(0, 0, 1, 32'h40, 32'h0, 3'b010, 32'h0);
    check("rbw_new", dout, 32'h22222222);

    // Reset with pending stores (RAM and IO)
    step(1, 1, 0, 32'h100, 32'h99, 3'b010, 32'h0);
    check("rst_mis", {31'b0, mis}, 32'h0);
    step(1, 1, 0, 32'h1100_0000, 32'h99, 3'b010, 32'h0);
    step(0, 0, 1, 32'h100, 32'h0, 3'b010, 32'h0);
    check("ram_retained", dout, 32'h1234BEEF);

    // Randomized phase over a small RAM window plus IO space
    step(1, 0, 0, 32'h0, 32'h0, 3'b010, 32'h0);
    for (int i = 0; i < 16; i++)
      step(0, 1, 0, 32'h400 + 32'(i * 4), $urandom, 3'b010, 32'h0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0)
        a = IO_BASE + 32'($urandom_range(0, 63));
      else
        a = 32'h400 + 32'($urandom_range(0, 63));
      d  = $urandom;
      sz = 3'($urandom_range(0, 7));
      w  = ($urandom_range(0, 2) == 0);
      l  = ($urandom_range(0, 1) == 0);
      step(($urandom_range(0, 99) == 0), w, l, a, d, sz, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
